mux_sel_arbiter: RTL and testbench

//   Round-robin select generator sitting directly upstream of the 4:1 mux. Arbitrates

---
 rtl/mux_sel_arbiter_if.sv | 14 +
 rtl/mux_sel_arbiter.sv | 98 +++++++++
 tb/tb_mux_sel_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the 4:1 mux select arbiter and its requesters.
// Handshake: req is a level held by each source for as long as it wants the mux; grant is the
// registered one-hot acknowledge, sig is the select index, and done marks a dwell that ran to completion.
interface mux_sel_arbiter_if;
  logic       en;
  logic [3:0] req;
  logic [1:0] sig;
  logic [3:0] grant;
  logic       busy;
  logic       done;

  modport master (output en, req, input sig, grant, busy, done);
  modport slave  (input en, req, output sig, grant, busy, done);
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux: each grant dwells HOLD_CYCLES clocks,
// then priority rotates to the index after the one just served.
module mux_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux_sel_arbiter_if.slave   bus,
  output logic               state_dbg
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_next;
  logic [1:0]       sig_q, sig_n;
  logic [1:0]       ptr_q, ptr_n;
  logic [3:0]       grant_q, grant_n;
  logic             done_q, done_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             found;
  logic [1:0]       pick;
  logic [1:0]       cand;

  // Walk offsets from high to low so the smallest offset from ptr is the one left in pick.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sig_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_next;
      sig_q   <= sig_n;
      ptr_q   <= ptr_n;
      grant_q <= grant_n;
      done_q  <= done_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_next = state;
    sig_n      = sig_q;
    ptr_n      = ptr_q;
    grant_n    = grant_q;
    done_n     = 1'b0;
    cnt_n      = cnt_q;
    case (state)
      IDLE: begin
        if (bus.en && found) begin
          state_next = GRANT;
          sig_n      = pick;
          grant_n    = 4'b0001 << pick;
          cnt_n      = CNT_LOAD;
        end
      end
      GRANT: begin
        // Dwell expiry outranks a dropped request so a full dwell still reports done.
        if (cnt_q == '0 || !bus.req[sig_q]) begin
          state_next = IDLE;
          grant_n    = '0;
          ptr_n      = sig_q + 2'd1;
          done_n     = (cnt_q == '0);
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.sig   = sig_q;
    bus.grant = grant_q;
    bus.busy  = (state == GRANT);
    bus.done  = done_q;
    state_dbg = (state == GRANT);
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter driving a 4:1 mux; a behavioural model feeds an expected queue.
module tb_mux_sel_arbiter;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_sel_arbiter_if bus ();
  mux_sel_arbiter_if bus1 ();
  logic state_dbg, state_dbg1;

  mux_sel_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg));
  mux_sel_arbiter #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(state_dbg1));

  logic [7:0] din [4];
  logic [7:0] result;
  assign result = din[bus.sig];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  // Behavioural reference: counts cycles spent in the dwell upward.
  logic [1:0] m_ptr, m_sig;
  logic [3:0] m_grant;
  logic       m_done;
  int         m_age;

  task automatic model_reset();
    m_ptr = 0; m_sig = 0; m_grant = 0; m_done = 0; m_age = 0;
  endtask

  task automatic model_edge(input logic en_v, input logic [3:0] req_v);
    bit hit;
    int j;
    if (m_grant == 4'b0) begin
      m_done = 1'b0;
      hit = 0;
      if (en_v && req_v != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          j = (int'(m_ptr) + k) % 4;
          if (!hit && req_v[j]) begin
            hit = 1; m_sig = 2'(j); m_grant = 4'(1 << j); m_age = 1;
          end
        end
      end
    end else if (m_age == HOLD || !req_v[m_sig]) begin
      m_done  = (m_age == HOLD);
      m_grant = 4'b0;
      m_ptr   = 2'((int'(m_sig) + 1) % 4);
    end else begin
      m_age++;
    end
  endtask

  task automatic do_reset();
    bus.en = 0; bus.req = 0; bus1.en = 0; bus1.req = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic tick(input logic en_v, input logic [3:0] req_v);
    bus.en = en_v; bus.req = req_v;
    for (int i = 0; i < 4; i++) din[i] = 8'($urandom_range(0, 255));
    @(posedge clk);
    model_edge(en_v, req_v);
    exp_q.push_back({m_done, |m_grant, m_grant, m_sig});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    rst = 1'b0; bus.en = 1; bus.req = 4'hF; bus1.en = 0; bus1.req = 0;
    #1 rst = 1'b1;
    #1;
    n_tests++; if (bus.sig !== 2'd0) begin n_fail++; $display("FAIL reset_sig got=%0d exp=0", bus.sig); end
    n_tests++; if (bus.grant !== 4'd0) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    @(negedge clk); @(negedge clk);
    n_tests++; if (bus.grant !== 4'd0) begin n_fail++; $display("FAIL reset_held_grant got=%b exp=0000", bus.grant); end
    rst = 1'b0;
    model_reset(); exp_q.delete();
    tick(1'b1, 4'hF);
    got = {bus.done, bus.busy, bus.grant, bus.sig}; exp = exp_q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL reset_first_grant got=%h exp=%h", got, exp); end
    n_tests++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_onehot got=%b exp=0001", bus.grant); end
  endtask

  task automatic test_sweep(input string name, input logic [3:0] req_v, input int cycles,
                            input int n_exp, input logic [1:0] want0, input logic [1:0] want1,
                            input logic [1:0] want2, input logic [1:0] want3, input logic [1:0] want4);
    logic [7:0] got, exp;
    logic prev_busy;
    int starts[$];
    logic [1:0] seq[$];
    logic [1:0] want [5];
    want = '{want0, want1, want2, want3, want4};
    do_reset();
    prev_busy = 0;
    for (int c = 1; c <= cycles; c++) begin
      tick(1'b1, req_v);
      got = {bus.done, bus.busy, bus.grant, bus.sig}; exp = exp_q.pop_front();
      n_tests++; if (got !== exp) begin n_fail++; $display("FAIL %s_cycle%0d got=%h exp=%h", name, c, got, exp); end
      if (exp[6]) begin
        n_tests++;
        if (result !== din[exp[1:0]]) begin n_fail++; $display("FAIL %s_mux%0d got=%h exp=%h", name, c, result, din[exp[1:0]]); end
      end
      if (bus.busy && !prev_busy) begin starts.push_back(c); seq.push_back(bus.sig); end
      prev_busy = bus.busy;
    end
    n_tests++; if (seq.size() != n_exp) begin n_fail++; $display("FAIL %s_grants got=%0d exp=%0d", name, seq.size(), n_exp); end
    for (int k = 0; k < n_exp && k < seq.size(); k++) begin
      n_tests++; if (seq[k] !== want[k]) begin n_fail++; $display("FAIL %s_seq%0d got=%0d exp=%0d", name, k, seq[k], want[k]); end
      n_tests++; if (starts[k] != 1 + (HOLD + 1) * k) begin n_fail++; $display("FAIL %s_start%0d got=%0d exp=%0d", name, k, starts[k], 1 + (HOLD + 1) * k); end
    end
  endtask

  task automatic test_early_release();
    logic [7:0] got, exp;
    logic en_t [4] = '{1, 1, 1, 1};
    logic [3:0] req_t [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0011};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick(en_t[c], req_t[c]);
      got = {bus.done, bus.busy, bus.grant, bus.sig}; exp = exp_q.pop_front();
      n_tests++; if (got !== exp) begin n_fail++; $display("FAIL early_cycle%0d got=%h exp=%h", c, got, exp); end
      if (c == 2) begin
        n_tests++; if (bus.grant !== 4'b0 || bus.done !== 1'b0 || bus.sig !== 2'd0) begin
          n_fail++; $display("FAIL early_release got grant=%b done=%b sig=%0d exp 0000/0/0", bus.grant, bus.done, bus.sig);
        end
      end
    end
    n_tests++; if (bus.sig !== 2'd1) begin n_fail++; $display("FAIL early_ptr_next got=%0d exp=1", bus.sig); end
  endtask

  task automatic test_en_drop();
    logic [7:0] got, exp;
    int busy_cnt = 0;
    int done_cnt = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(c == 0, 4'b0100);
      got = {bus.done, bus.busy, bus.grant, bus.sig}; exp = exp_q.pop_front();
      n_tests++; if (got !== exp) begin n_fail++; $display("FAIL en_drop_cycle%0d got=%h exp=%h", c, got, exp); end
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
    end
    n_tests++; if (busy_cnt != HOLD || done_cnt != 1) begin
      n_fail++; $display("FAIL en_drop_dwell got busy=%0d done=%0d exp busy=%0d done=1", busy_cnt, done_cnt, HOLD);
    end
    tick(1'b1, 4'b0100);
    got = {bus.done, bus.busy, bus.grant, bus.sig}; exp = exp_q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL en_resume got=%h exp=%h", got, exp); end
    n_tests++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL en_resume_grant got=%b exp=0100", bus.grant); end
  endtask

  task automatic test_reset_mid_dwell();
    logic [7:0] got, exp;
    do_reset();
    tick(1'b1, 4'b1000);
    tick(1'b1, 4'b1000);
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.sig !== 2'd0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got grant=%b busy=%b sig=%0d done=%b exp 0000/0/0/0", bus.grant, bus.busy, bus.sig, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(1'b0, 4'b0000);
    got = {bus.done, bus.busy, bus.grant, bus.sig}; exp = exp_q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL mid_reset_after got=%h exp=%h", got, exp); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_done got=%b exp=0", bus.done); end
  endtask

  task automatic test_hold1();
    do_reset();
    bus1.en = 1; bus1.req = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (bus1.grant !== ((i % 2 == 1) ? 4'b0001 : 4'b0000) || bus1.done !== (i % 2 == 0)) begin
        n_fail++; $display("FAIL hold1_cycle%0d got grant=%b done=%b exp grant=%b done=%b",
                            i, bus1.grant, bus1.done, (i % 2 == 1) ? 4'b0001 : 4'b0000, i % 2 == 0);
      end
    end
    bus1.en = 0; bus1.req = 0;
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      tick($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      got = {bus.done, bus.busy, bus.grant, bus.sig}; exp = exp_q.pop_front();
      n_tests++; if (got !== exp) begin n_fail++; $display("FAIL random_cycle%0d got=%h exp=%h", c, got, exp); end
      if (exp[6]) begin
        n_tests++;
        if (result !== din[exp[1:0]]) begin n_fail++; $display("FAIL random_mux%0d got=%h exp=%h", c, result, din[exp[1:0]]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    test_reset();
    test_sweep("round_robin", 4'b1111, 25, 5, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0);
    test_sweep("alternate", 4'b1010, 20, 4, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0);
    test_early_release();
    test_en_drop();
    test_reset_mid_dwell();
    test_hold1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
